// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pll_reset_sequencer
// Description : PLL lock supervisor; pulses the PLL reset, waits for stable
//               lock, then releases downstream resets one at a time.
// Revision    : 1.0
// ============================================================================
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 1000000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int STAGE_GAP      = 64,
    parameter int NUM_RESETS     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pll_locked,
    output logic                  pll_rst,
    output logic [NUM_RESETS-1:0] rst_out,
    output logic                  ready,
    output logic [2:0]            state,
    output logic [7:0]            relock_count
);

    localparam int c_MAX_AB = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int c_MAX_CD = (STABLE_CYCLES > STAGE_GAP) ? STABLE_CYCLES : STAGE_GAP;
    localparam int c_MAX    = (c_MAX_AB > c_MAX_CD) ? c_MAX_AB : c_MAX_CD;
    localparam int c_CNT_W  = $clog2(c_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_ZERO        = '0;
    localparam logic [c_CNT_W-1:0] c_ONE         = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_PLL_RST_END = c_CNT_W'(PLL_RST_CYCLES);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_END = c_CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_STABLE_END  = c_CNT_W'(STABLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_END     = c_CNT_W'(STAGE_GAP - 1);

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } state_t;

    logic                  sync1_q;
    logic                  locked_s_q;
    state_t                state_q,   state_d;
    logic [c_CNT_W-1:0]    cnt_q,     cnt_d;
    logic                  pll_rst_q, pll_rst_d;
    logic [NUM_RESETS-1:0] rst_out_q, rst_out_d;
    logic                  ready_q,   ready_d;
    logic [7:0]            relock_q,  relock_d;
    logic                  retry;

    // cnt_q is shared by all states. PLL_RST counts its entry cycle as 1, so
    // the pulse spans exactly PLL_RST_CYCLES cycles after entry; the reset
    // value of 0 accounts for the cycle in which rst itself is released.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + c_ONE;
        rst_out_d = rst_out_q;
        relock_d  = relock_q;
        retry     = 1'b0;

        case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == c_PLL_RST_END) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = c_ZERO;
                end
            end
            ST_WAIT_LOCK: begin
                if (locked_s_q) begin
                    state_d = ST_STABLE;
                    cnt_d   = c_ONE;
                end else if (cnt_q == c_TIMEOUT_END) begin
                    retry = 1'b1;
                end
            end
            ST_STABLE: begin
                if (!locked_s_q) begin
                    retry = 1'b1;
                end else if (cnt_q >= c_STABLE_END) begin
                    state_d   = ST_RELEASE;
                    cnt_d     = c_ZERO;
                    rst_out_d = rst_out_q << 1;
                    if (rst_out_d == '0) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RELEASE: begin
                if (!locked_s_q) begin
                    retry = 1'b1;
                end else if (cnt_q == c_GAP_END) begin
                    // Shifting in zeros releases bit 0 first, then bit 1, ...
                    cnt_d     = c_ZERO;
                    rst_out_d = rst_out_q << 1;
                    if (rst_out_d == '0) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q;
                if (!locked_s_q) begin
                    retry = 1'b1;
                end
            end
            default: begin
                state_d   = ST_PLL_RST;
                cnt_d     = c_ONE;
                rst_out_d = '1;
            end
        endcase

        if (retry) begin
            state_d   = ST_PLL_RST;
            cnt_d     = c_ONE;
            rst_out_d = '1;
            if (relock_q != 8'hFF) begin
                relock_d = relock_q + 8'd1;
            end
        end

        pll_rst_d = (state_d == ST_PLL_RST);
        ready_d   = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            locked_s_q <= 1'b0;
            state_q    <= ST_PLL_RST;
            cnt_q      <= c_ZERO;
            pll_rst_q  <= 1'b1;
            rst_out_q  <= '1;
            ready_q    <= 1'b0;
            relock_q   <= 8'd0;
        end else begin
            sync1_q    <= pll_locked;
            locked_s_q <= sync1_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pll_rst_q  <= pll_rst_d;
            rst_out_q  <= rst_out_d;
            ready_q    <= ready_d;
            relock_q   <= relock_d;
        end
    end

    assign pll_rst      = pll_rst_q;
    assign rst_out      = rst_out_q;
    assign ready        = ready_q;
    assign state        = state_q;
    assign relock_count = relock_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_reset_sequencer
// Description : Directed self-checking bench for pll_reset_sequencer.
// Revision    : 1.0
// ============================================================================
module tb_pll_reset_sequencer;

    localparam int NR = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          pll_locked;
    logic          pll_rst;
    logic [NR-1:0] rst_out;
    logic          ready;
    logic [2:0]    state;
    logic [7:0]    relock_count;

    int cyc;
    int total;
    int bad;
    bit all_held;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (20),
        .STABLE_CYCLES  (8),
        .STAGE_GAP      (3),
        .NUM_RESETS     (NR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pll_locked   (pll_locked),
        .pll_rst      (pll_rst),
        .rst_out      (rst_out),
        .ready        (ready),
        .state        (state),
        .relock_count (relock_count)
    );

    always #5 clk = ~clk;

    // Cycle N means the value present just after the Nth post-reset edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        pll_locked = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        cyc = -1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;

        // ---------------- normal bring-up, then lock loss in RUN -------------
        do_reset();
        chk("rst_pll_rst", 32'(pll_rst), 1);
        chk("rst_rst_out", 32'(rst_out), 3'b111);
        chk("rst_ready",   32'(ready), 0);
        chk("rst_state",   32'(state), 0);
        chk("rst_relock",  32'(relock_count), 0);
        for (int c = 0; c <= 3; c++) begin
            wait_cyc(c);
            chk("bringup_pll_rst_hi", 32'(pll_rst), 1);
        end
        wait_cyc(4);
        chk("bringup_pll_rst_lo", 32'(pll_rst), 0);
        chk("bringup_wait_state", 32'(state), 1);
        wait_cyc(10);
        pll_locked = 1'b1;
        wait_cyc(11);
        chk("bringup_locked_s_11", 32'(dut.locked_s_q), 0);
        wait_cyc(12);
        chk("bringup_locked_s_12", 32'(dut.locked_s_q), 1);
        wait_cyc(13);
        chk("bringup_stable_state", 32'(state), 2);
        wait_cyc(19);
        chk("bringup_rst_out_19", 32'(rst_out), 3'b111);
        wait_cyc(20);
        chk("bringup_rst_out_20", 32'(rst_out), 3'b110);
        chk("bringup_release_st", 32'(state), 3);
        wait_cyc(22);
        chk("bringup_rst_out_22", 32'(rst_out), 3'b110);
        wait_cyc(23);
        chk("bringup_rst_out_23", 32'(rst_out), 3'b100);
        wait_cyc(25);
        chk("bringup_ready_25", 32'(ready), 0);
        wait_cyc(26);
        chk("bringup_rst_out_26", 32'(rst_out), 3'b000);
        chk("bringup_ready_26",   32'(ready), 1);
        chk("bringup_run_state",  32'(state), 4);
        chk("bringup_relock",     32'(relock_count), 0);

        wait_cyc(40);
        pll_locked = 1'b0;
        wait_cyc(42);
        chk("loss_ready_42", 32'(ready), 1);
        wait_cyc(43);
        chk("loss_rst_out_43", 32'(rst_out), 3'b111);
        chk("loss_ready_43",   32'(ready), 0);
        chk("loss_pll_rst_43", 32'(pll_rst), 1);
        chk("loss_state_43",   32'(state), 0);
        chk("loss_relock_43",  32'(relock_count), 1);
        wait_cyc(46);
        chk("loss_pll_rst_46", 32'(pll_rst), 1);
        wait_cyc(47);
        chk("loss_pll_rst_47", 32'(pll_rst), 0);

        // ---------------- relock, then rst asserted mid-RELEASE --------------
        wait_cyc(50);
        pll_locked = 1'b1;
        wait_cyc(59);
        chk("midrel_rst_out_59", 32'(rst_out), 3'b111);
        wait_cyc(60);
        chk("midrel_rst_out_60", 32'(rst_out), 3'b110);
        wait_cyc(61);
        chk("midrel_rst_out_61", 32'(rst_out), 3'b110);
        rst = 1'b1;
        wait_cyc(62);
        chk("midrel_rst_out", 32'(rst_out), 3'b111);
        chk("midrel_pll_rst", 32'(pll_rst), 1);
        chk("midrel_state",   32'(state), 0);
        chk("midrel_relock",  32'(relock_count), 0);
        chk("midrel_ready",   32'(ready), 0);

        // ---------------- glitch during STABLE -------------------------------
        do_reset();
        all_held = 1'b1;
        for (int c = 0; c <= 18; c++) begin
            wait_cyc(c);
            if (c == 10) pll_locked = 1'b1;
            if (c == 15) pll_locked = 1'b0;
            if (c == 16) pll_locked = 1'b1;
            if (rst_out !== 3'b111) all_held = 1'b0;
        end
        chk("glitch_rst_out_held", 32'(all_held), 1);
        chk("glitch_state_18",     32'(state), 0);
        chk("glitch_pll_rst_18",   32'(pll_rst), 1);
        chk("glitch_relock_18",    32'(relock_count), 1);

        // ---------------- timeout and lock arriving together -----------------
        do_reset();
        wait_cyc(21);
        pll_locked = 1'b1;
        wait_cyc(23);
        chk("tie_state_23",  32'(state), 1);
        wait_cyc(24);
        chk("tie_state_24",  32'(state), 2);
        chk("tie_pll_rst",   32'(pll_rst), 0);
        chk("tie_relock",    32'(relock_count), 0);

        // ---------------- lock timeout and saturation ------------------------
        do_reset();
        wait_cyc(23);
        chk("tmo_pll_rst_23", 32'(pll_rst), 0);
        chk("tmo_relock_23",  32'(relock_count), 0);
        wait_cyc(24);
        chk("tmo_pll_rst_24", 32'(pll_rst), 1);
        chk("tmo_relock_24",  32'(relock_count), 1);
        chk("tmo_state_24",   32'(state), 0);
        wait_cyc(27);
        chk("tmo_pll_rst_27", 32'(pll_rst), 1);
        wait_cyc(28);
        chk("tmo_pll_rst_28", 32'(pll_rst), 0);
        wait_cyc(47);
        chk("tmo_relock_47",  32'(relock_count), 1);
        wait_cyc(48);
        chk("tmo_relock_48",  32'(relock_count), 2);
        chk("tmo_pll_rst_48", 32'(pll_rst), 1);
        wait_cyc(24 * 255 - 1);
        chk("sat_relock_254", 32'(relock_count), 254);
        wait_cyc(24 * 255);
        chk("sat_relock_255", 32'(relock_count), 255);
        wait_cyc(24 * 256);
        chk("sat_relock_hold", 32'(relock_count), 255);
        wait_cyc(24 * 300 + 5);
        chk("sat_relock_end",  32'(relock_count), 255);
        chk("sat_rst_out_end", 32'(rst_out), 3'b111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Lock supervisor and reset sequencer that sits directly downstream of the system PLL. It runs on the free-running 50 MHz reference clock and drives the PLL's reset input. It watches the PLL `locked` output and releases per-domain resets (SDRAM, camera, video) in a fixed order, one at a time, only after lock has been stable. On lock loss or lock timeout it re-asserts every downstream reset and re-initialises the PLL.

## Interface
- `PLL_RST_CYCLES`, default 16: length of the PLL reset pulse, in cycles.
- `LOCK_TIMEOUT`, default 1000000: cycles to wait for lock before retrying.
- `STABLE_CYCLES`, default 1024: consecutive synchronised lock samples required before releasing resets.
- `STAGE_GAP`, default 64: cycles between successive reset releases.
- `NUM_RESETS`, default 3: number of sequenced reset outputs.

- `clk`, input, 1: free-running 50 MHz reference clock (the same net as the PLL refclk).
- `rst`, input, 1: synchronous, active-high reset.
- `pll_locked`, input, 1: PLL `locked`. Asynchronous to `clk`.
- `pll_rst`, output, 1: drives the PLL `rst` input. Active-high.
- `rst_out`, output, NUM_RESETS: per-domain active-high resets. Bit 0 is released first.
- `ready`, output, 1: high while every `rst_out` bit is deasserted (state RUN).
- `state`, output, 3: current state encoding. PLL_RST=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4.
- `relock_count`, output, 8: number of retries (timeouts plus lock losses). Saturates at 255.

## Operation
- `pll_locked` passes through a 2-flop synchroniser; its output is `locked_s`. Only `locked_s` is used internally.
- Reset (`rst`=1): state goes to PLL_RST, `pll_rst`=1, `rst_out`=all ones, `ready`=0, `relock_count`=0, and all counters clear. The synchroniser flops also clear.
- PLL_RST: `pll_rst` is held high for exactly PLL_RST_CYCLES cycles after entry, then the state moves to WAIT_LOCK. `rst_out` stays all ones.
- WAIT_LOCK: `pll_rst`=0 and a timeout counter runs.
  - If `locked_s` is 1, move to STABLE.
  - If LOCK_TIMEOUT cycles elapse without `locked_s`, move to PLL_RST and increment `relock_count`.
- STABLE: count consecutive cycles with `locked_s`=1.
  - On reaching STABLE_CYCLES, move to RELEASE.
  - If `locked_s` drops to 0, move to PLL_RST and increment `relock_count`. Partial counts are discarded.
- RELEASE: `rst_out[0]` clears on the first RELEASE cycle. Each `rst_out[i]` clears STAGE_GAP cycles after `rst_out[i-1]`. Once `rst_out[NUM_RESETS-1]` clears, the state moves to RUN.
- RUN: `ready`=1 and `rst_out`=0.
- Lock loss in RELEASE or RUN (`locked_s`=0): on the next clock, `rst_out`=all ones, `ready`=0, state=PLL_RST, and `relock_count` increments.
- `relock_count` saturates at 255 and never wraps.
- All outputs are registered. There are no combinational paths from input to output.

## Timing
- Cycle 0 is the first rising edge at which `rst` is sampled low.
- `pll_rst` is high through cycle PLL_RST_CYCLES−1 and low from cycle PLL_RST_CYCLES.
- `pll_locked` to `locked_s` latency is 2 cycles.
- If `locked_s` first goes high at cycle T in WAIT_LOCK and stays high:
  - `rst_out[0]` is low at cycle T+STABLE_CYCLES.
  - `rst_out[i]` is low at cycle T+STABLE_CYCLES+i·STAGE_GAP.
  - `ready` rises in the same cycle as the last `rst_out` bit falls.
- Lock loss: if `locked_s` falls at cycle L, all `rst_out` bits and `ready` have their reset values at L+1. That is 3 cycles after `pll_locked` falls. `pll_rst` rises at L+1.
- Asserting `rst` mid-operation: all outputs return to their reset values at the next clock, regardless of state.
- Simultaneous timeout and `locked_s` rising in WAIT_LOCK: lock wins, and the state moves to STABLE.

## Test plan
Bench parameters for all scenarios: PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, STAGE_GAP=3, NUM_RESETS=3.

- **Normal bring-up.** Release `rst` at cycle 0 and raise `pll_locked` at cycle 10. Required response:
  - `pll_rst` is high on cycles 0–3.
  - `locked_s` is high at cycle 12.
  - `rst_out` is 110 at cycle 20, 100 at cycle 23, and 000 at cycle 26.
  - `ready`=1 at cycle 26, `relock_count`=0.
- **Lock timeout.** Hold `pll_locked`=0. Required response: `pll_rst` re-pulses at cycle 24 for 4 cycles, `relock_count`=1, and it reaches 2 at cycle 48.
- **Glitch during STABLE.** Raise `pll_locked` at cycle 10, then drop it for 1 cycle at 15. Required response: state returns to PLL_RST at cycle 18, `rst_out` stays 111 throughout, `relock_count`=1.
- **Lock loss in RUN.** After `ready`=1, drop `pll_locked` at cycle 40. Required response: `rst_out`=111, `ready`=0, and `pll_rst`=1 at cycle 43; `relock_count` increments.
- **Saturation.** Hold `pll_locked`=0 for 300 timeout periods. Required response: `relock_count` stops at 255 and never wraps.
- **Reset mid-RELEASE.** Assert `rst` in the cycle after `rst_out`=110. Required response: at the next clock, `rst_out`=111, `pll_rst`=1, state=0, `relock_count`=0.
